dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single data-memory port between two requesters.
- Requester 0 is the pipeline Memory stage (CPU); it has default priority.
- Requester 1 is an external port (program loader / debug DMA); it has starvation protection and optional locked bursts.
- Sits between the Memory stage and the data memory. Returns a stall to the hazard unit whenever the CPU access is deferred.

Parameters:
STARVE_LIMIT, 8, consecutive denied ext cycles after which ext wins over CPU (>=1)
MAX_LOCK, 4, max consecutive ext beats in one locked burst (>=1)
STALL_CNT_W, 32, width of the saturating CPU-stall statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
MemReadM  in  1  CPU load request
MemWriteM  in  1  CPU store request
StoreTypeM  in  2  CPU store size code, passed through to memory
ALUResultM  in  32  CPU byte address
WriteDataM  in  32  CPU store data
ReadDataM  out  32  CPU load data (combinational from memory)
StallM  out  1  CPU access deferred this cycle
ext_req  in  1  ext access request, held until ext_gnt
ext_we  in  1  ext write (1) / read (0)
ext_lock  in  1  ext asks to keep the port next cycle
ext_store_type  in  2  ext store size code
ext_addr  in  32  ext byte address
ext_wdata  in  32  ext store data
ext_gnt  out  1  ext access performed this cycle
ext_rdata  out  32  registered ext read data
ext_rvalid  out  1  ext_rdata valid (one cycle after a granted read)
mem_we  out  1  memory write enable
mem_store_type  out  2  memory store size code
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data (combinational, same cycle as mem_addr)
stall_count  out  STALL_CNT_W  saturating count of StallM cycles

Behaviour:
- cpu_req = MemReadM | MemWriteM.
- Grant rule (combinational): ext_gnt = ext_req & (~cpu_req | starve_cnt==STARVE_LIMIT | lock_active).
- StallM = cpu_req & ext_gnt. The CPU holds its request stable while stalled.
- Port mux:
  - ext_gnt=1: mem_addr, mem_wdata and mem_store_type take the ext_* values; mem_we=ext_we.
  - ext_gnt=0: they take the CPU values; mem_we=MemWriteM.
  - ReadDataM=mem_rdata at all times; it is meaningful only when ~StallM.
- Write ordering: writes commit at the clk edge ending the granted cycle. Each cycle performs at most one access.
- starve_cnt (registered, 0..STARVE_LIMIT, saturating):
  - ext_req & ~ext_gnt -> starve_cnt+1.
  - ext_gnt or ~ext_req -> 0.
  - Worst-case CPU-vs-ext wait: ext is granted on the (STARVE_LIMIT+1)th cycle of continuous denial.
- Lock (registered lock_active, lock_cnt 0..MAX_LOCK-1):
  - ext_gnt & ext_lock & (lock_cnt+1 < MAX_LOCK) -> lock_active=1, lock_cnt+1.
  - Otherwise -> lock_active=0, lock_cnt=0.
  - A locked burst therefore lasts at most MAX_LOCK consecutive beats. The CPU is guaranteed the port at the end of the burst if it requests, because starve_cnt is 0.
  - MAX_LOCK=1 disables locking.
  - lock_active with ext_req=0 grants nothing and clears next cycle.
- Ext read response: ext_gnt & ~ext_we -> next cycle ext_rvalid=1 and ext_rdata=mem_rdata sampled at the grant cycle. Otherwise ext_rvalid=0 and ext_rdata holds its value.
- stall_count increments each StallM cycle and saturates at all-ones.
- Reset, applied in any cycle including mid-burst:
  - ext_rvalid=0, ext_rdata=0, stall_count=0, starve_cnt=0, lock_active=0, lock_cnt=0.
  - Combinational outputs follow the inputs with reset state. During the rst cycle itself, granting is not suppressed; the CPU side owns the port unless ext_req & ~cpu_req.
- Simultaneous events:
  - A CPU read and an ext read in the same cycle: only one is performed; the loser repeats next cycle.
  - An ext_req drop while starve_cnt is saturated resets the counter.

Decomposition:
- Shared package: store-type codes (SB/SH/SW) already used by the memory.
- One natural sub-module: arb_starve_lock_ctrl. It holds starve_cnt, lock_active and lock_cnt, and produces ext_gnt.
- The top level keeps the mux, read-response register and statistics counter.

Test Plan:
(STARVE_LIMIT=4, MAX_LOCK=4 unless noted)
1. No ext_req; CPU SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> StallM=0 both cycles; ReadDataM=0xDEADBEEF; stall_count=0.
2. CPU idle; ext write 0x20=0x12345678, then ext read 0x20 -> ext_gnt=1 each cycle; ext_rvalid=1 the cycle after the read with ext_rdata=0x12345678.
3. cpu_req held 1 continuously, ext_req held from cycle 0 -> ext_gnt=0 cycles 0-3, ext_gnt=1 and StallM=1 at cycle 4, CPU served cycle 5; stall_count=1.
4. CPU idle at ext's first beat, ext_lock=1 for 6 beats, CPU requesting from beat 2 -> ext granted beats 1-4, CPU granted beat 5 (ext denied), StallM=1 for 3 cycles.
5. Reset asserted mid locked burst (lock_active=1) -> next cycle lock_active=0, starve_cnt=0, ext_rvalid=0, stall_count=0; with cpu_req=1 the CPU wins immediately.
6. STALL_CNT_W=2, force 5 stall cycles -> stall_count saturates at 3.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   store_type_e : store size codes understood by the data memory (SB/SH/SW)
//   cnt_w()      : width needed to hold a counter value 0..max_val (at least 1)
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_SB = 2'd0,
    ST_SH = 2'd1,
    ST_SW = 2'd2
  } store_type_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// External requester port of the data-memory arbiter (loader / debug DMA).
//   master : the external requester (drives request, address, data, lock)
//   slave  : the arbiter (returns grant and registered read response)
interface dmem_port_arbiter_if;
  import dmem_port_arbiter_pkg::*;

  logic        ext_req;
  logic        ext_we;
  logic        ext_lock;
  logic [1:0]  ext_store_type;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;

  modport master (
    output ext_req, ext_we, ext_lock, ext_store_type, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid
  );

  modport slave (
    input  ext_req, ext_we, ext_lock, ext_store_type, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid
  );

endinterface

// File: rtl/dmem_port_arbiter_arb_starve_lock_ctrl.sv
// Grant decision for the external requester: CPU has priority unless the
// external side has been starved for STARVE_LIMIT cycles or holds a lock.
//   clk, rst  : clock, synchronous active-high reset
//   cpu_req   : CPU wants the port this cycle
//   ext_req   : external side wants the port this cycle
//   ext_lock  : external side asks to keep the port next cycle
//   ext_gnt   : external access performed this cycle
//
// state                  | meaning
// lock_active=0          | normal priority, starve_cnt counts denied ext cycles
// lock_active=1          | ext owns the port next beat if it still requests
// starve_cnt=STARVE_LIMIT| ext wins over the CPU on its next request cycle
module arb_starve_lock_ctrl
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_LOCK     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic ext_req,
  input  logic ext_lock,
  output logic ext_gnt
);

  localparam int SW = cnt_w(STARVE_LIMIT);
  localparam int LW = cnt_w(MAX_LOCK - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LW:0]   LOCK_MAX   = (LW + 1)'(MAX_LOCK);

  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic          lock_active, lock_active_nxt;
  logic [LW:0]   lock_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= '0;
      lock_cnt    <= '0;
      lock_active <= 1'b0;
    end else begin
      starve_cnt  <= starve_nxt;
      lock_cnt    <= lock_cnt_nxt;
      lock_active <= lock_active_nxt;
    end
  end

  always_comb begin
    starve_nxt      = '0;
    lock_cnt_nxt    = '0;
    lock_active_nxt = 1'b0;
    lock_inc        = {1'b0, lock_cnt} + (LW + 1)'(1);
    if (ext_req && !ext_gnt)
      starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
    if (ext_gnt && ext_lock && (lock_inc < LOCK_MAX)) begin
      lock_active_nxt = 1'b1;
      lock_cnt_nxt    = lock_inc[LW-1:0];
    end
  end

  // While rst is high the registered state is treated as already cleared,
  // so only an uncontested ext request is granted in the reset cycle.
  always_comb begin
    ext_gnt = ext_req &
              (~cpu_req | (~rst & ((starve_cnt == STARVE_MAX) | lock_active)));
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU Memory stage and an
// external requester, stalls the CPU when it loses, returns registered read
// data to the external side and counts CPU stall cycles.
//   clk, rst        : clock, synchronous active-high reset
//   MemReadM/WriteM : CPU load/store request; StoreTypeM, ALUResultM, WriteDataM
//   ReadDataM       : CPU load data (combinational from memory)
//   StallM          : CPU access deferred this cycle
//   ext             : external requester port (slave side)
//   mem_*           : data memory port, mem_rdata combinational
//   stall_count     : saturating count of StallM cycles
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_LOCK     = 4,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [1:0]             StoreTypeM,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadDataM,
  output logic                   StallM,
  dmem_port_arbiter_if.slave     ext,
  output logic                   mem_we,
  output logic [1:0]             mem_store_type,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                   cpu_req;
  logic                   ext_gnt;
  logic                   rvalid_q;
  logic [31:0]            rdata_q;
  logic [STALL_CNT_W-1:0] stall_q;

  assign cpu_req = MemReadM | MemWriteM;

  arb_starve_lock_ctrl #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .MAX_LOCK     (MAX_LOCK)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .ext_req  (ext.ext_req),
    .ext_lock (ext.ext_lock),
    .ext_gnt  (ext_gnt)
  );

  assign StallM    = cpu_req & ext_gnt;
  assign ReadDataM = mem_rdata;

  always_comb begin
    if (ext_gnt) begin
      mem_we         = ext.ext_we;
      mem_store_type = ext.ext_store_type;
      mem_addr       = ext.ext_addr;
      mem_wdata      = ext.ext_wdata;
    end else begin
      mem_we         = MemWriteM;
      mem_store_type = StoreTypeM;
      mem_addr       = ALUResultM;
      mem_wdata      = WriteDataM;
    end
  end

  // Memory read data is only valid in the grant cycle, so capture it here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= ext_gnt & ~ext.ext_we;
      if (ext_gnt && !ext.ext_we)
        rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (StallM && (stall_q != '1))
      stall_q <= stall_q + STALL_CNT_W'(1);
  end

  assign ext.ext_gnt    = ext_gnt;
  assign ext.ext_rvalid = rvalid_q;
  assign ext.ext_rdata  = rdata_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_LOCK     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM, MemWriteM;
  logic [1:0]  StoreTypeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM, ReadDataM2;
  logic        StallM, StallM2;
  logic        mem_we, mem_we2;
  logic [1:0]  mem_store_type, mem_store_type2;
  logic [31:0] mem_addr, mem_addr2, mem_wdata, mem_wdata2, mem_rdata, mem_rdata2;
  logic [31:0] stall_count;
  logic [1:0]  stall_count2;
  logic        mem_clr;

  always #5 clk = ~clk;

  dmem_port_arbiter_if ext_if ();
  dmem_port_arbiter_if ext_if2 ();

  assign ext_if2.ext_req        = ext_if.ext_req;
  assign ext_if2.ext_we         = ext_if.ext_we;
  assign ext_if2.ext_lock       = ext_if.ext_lock;
  assign ext_if2.ext_store_type = ext_if.ext_store_type;
  assign ext_if2.ext_addr       = ext_if.ext_addr;
  assign ext_if2.ext_wdata      = ext_if.ext_wdata;

  dmem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK), .STALL_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .StoreTypeM(StoreTypeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .ext(ext_if.slave),
    .mem_we(mem_we), .mem_store_type(mem_store_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_count(stall_count)
  );

  dmem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK), .STALL_CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .StoreTypeM(StoreTypeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM2), .StallM(StallM2), .ext(ext_if2.slave),
    .mem_we(mem_we2), .mem_store_type(mem_store_type2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .stall_count(stall_count2)
  );

  // Word-addressed data memory seen by the DUT (addresses 0x00..0xFC).
  logic [31:0] mem [0:63];
  assign mem_rdata  = mem[mem_addr[7:2]];
  assign mem_rdata2 = mem[mem_addr2[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:63];
  int          m_wait;
  int          m_beats;
  bit          m_locked;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  longint      m_stalls;
  bit          last_stall, last_win;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic eval();
    bit          cpu_req, win, stall;
    logic [5:0]  ci, ei;
    logic [31:0] sat_exp;
    cpu_req = MemReadM || MemWriteM;
    win     = ext_if.ext_req &&
              (!cpu_req || (!rst && (m_wait >= STARVE_LIMIT || m_locked)));
    stall   = cpu_req && win;
    ci      = ALUResultM[7:2];
    ei      = ext_if.ext_addr[7:2];
    sat_exp = (m_stalls > 3) ? 32'd3 : m_stalls[31:0];

    chk_eq("ext_gnt", ext_if.ext_gnt, win);
    chk_eq("StallM", StallM, stall);
    chk_eq("mem_we", mem_we, win ? ext_if.ext_we : MemWriteM);
    chk_eq("mem_addr", mem_addr, win ? ext_if.ext_addr : ALUResultM);
    chk_eq("mem_wdata", mem_wdata, win ? ext_if.ext_wdata : WriteDataM);
    chk_eq("mem_store_type", mem_store_type, win ? ext_if.ext_store_type : StoreTypeM);
    if (MemReadM && !win) chk_eq("ReadDataM", ReadDataM, ref_mem[ci]);
    chk_eq("ext_rvalid", ext_if.ext_rvalid, m_rvalid);
    chk_eq("ext_rdata", ext_if.ext_rdata, m_rdata);
    chk_eq("stall_count", stall_count, m_stalls[31:0]);
    chk_eq("stall_count_w2", {30'b0, stall_count2}, sat_exp);

    if (rst) begin
      m_wait = 0; m_beats = 0; m_locked = 0;
      m_rvalid = 0; m_rdata = '0; m_stalls = 0;
    end else begin
      if (stall) m_stalls++;
      m_rvalid = win && !ext_if.ext_we;
      if (m_rvalid) m_rdata = ref_mem[ei];
      if (ext_if.ext_req && !win) m_wait = (m_wait >= STARVE_LIMIT) ? STARVE_LIMIT : m_wait + 1;
      else m_wait = 0;
      if (win) begin
        m_beats  = m_locked ? m_beats + 1 : 1;
        m_locked = ext_if.ext_lock && (m_beats < MAX_LOCK);
        if (!m_locked) m_beats = 0;
      end else begin
        m_locked = 0; m_beats = 0;
      end
    end
    if (win && ext_if.ext_we) ref_mem[ei] = ext_if.ext_wdata;
    else if (!win && MemWriteM) ref_mem[ci] = WriteDataM;
    last_stall = stall;
    last_win   = win;
  endtask

  task automatic settle();
    #3;
    eval();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = d; StoreTypeM = ST_SW;
  endtask

  task automatic set_ext(input bit rq, input bit we, input bit lk, input logic [31:0] a, input logic [31:0] d);
    ext_if.ext_req = rq; ext_if.ext_we = we; ext_if.ext_lock = lk;
    ext_if.ext_addr = a; ext_if.ext_wdata = d; ext_if.ext_store_type = ST_SW;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 199) == 0);
    if (!last_stall) begin
      case ($urandom_range(0, 3))
        0: begin MemReadM = 0; MemWriteM = 0; end
        1, 2: begin MemReadM = 1; MemWriteM = 0; end
        default: begin MemReadM = 0; MemWriteM = 1; end
      endcase
      ALUResultM = {24'h0, 6'($urandom), 2'b00};
      WriteDataM = $urandom;
      StoreTypeM = 2'($urandom_range(0, 2));
    end
    if (!(ext_if.ext_req && !last_win)) begin
      ext_if.ext_req        = ($urandom_range(0, 2) != 0);
      ext_if.ext_we         = $urandom_range(0, 1);
      ext_if.ext_lock       = $urandom_range(0, 1);
      ext_if.ext_addr       = {24'h0, 6'($urandom), 2'b00};
      ext_if.ext_wdata      = $urandom;
      ext_if.ext_store_type = 2'($urandom_range(0, 2));
    end
  endtask

  initial begin
    int k;
    mem_clr = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    m_wait = 0; m_beats = 0; m_locked = 0; m_rvalid = 0; m_rdata = '0; m_stalls = 0;
    last_stall = 0; last_win = 0;
    set_cpu(0, 0, 32'h0, 32'h0);
    set_ext(0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    rst = 1'b0;

    // CPU store then load, no ext traffic
    set_cpu(0, 1, 32'h10, 32'hDEADBEEF);
    settle(); chk_eq("t1_sw_stall", StallM, 1'b0); advance();
    set_cpu(1, 0, 32'h10, 32'h0);
    settle();
    chk_eq("t1_lw_stall", StallM, 1'b0);
    chk_eq("t1_lw_data", ReadDataM, 32'hDEADBEEF);
    chk_eq("t1_stall_count", stall_count, 32'd0);
    advance();

    // Ext write then read with CPU idle
    set_cpu(0, 0, 32'h0, 32'h0);
    set_ext(1, 1, 0, 32'h20, 32'h12345678);
    settle(); chk_eq("t2_wr_gnt", ext_if.ext_gnt, 1'b1); advance();
    set_ext(1, 0, 0, 32'h20, 32'h0);
    settle(); chk_eq("t2_rd_gnt", ext_if.ext_gnt, 1'b1); advance();
    set_ext(0, 0, 0, 32'h0, 32'h0);
    settle();
    chk_eq("t2_rvalid", ext_if.ext_rvalid, 1'b1);
    chk_eq("t2_rdata", ext_if.ext_rdata, 32'h12345678);
    advance();

    // Starvation: ext wins on its 5th consecutive request cycle
    set_cpu(1, 0, 32'h10, 32'h0);
    set_ext(1, 0, 0, 32'h20, 32'h0);
    for (int c = 0; c < 4; c++) begin
      settle(); chk_eq("t3_deny", ext_if.ext_gnt, 1'b0); advance();
    end
    settle();
    chk_eq("t3_gnt", ext_if.ext_gnt, 1'b1);
    chk_eq("t3_stall", StallM, 1'b1);
    advance();
    set_ext(0, 0, 0, 32'h0, 32'h0);
    settle();
    chk_eq("t3_cpu_served", StallM, 1'b0);
    chk_eq("t3_cpu_data", ReadDataM, 32'hDEADBEEF);
    advance();
    set_cpu(0, 0, 32'h0, 32'h0);
    settle(); chk_eq("t3_stall_count", stall_count, 32'd1); advance();

    // Locked burst of at most MAX_LOCK beats, then CPU gets the port
    k = 0;
    set_ext(1, 1, 1, 32'h40, $urandom);
    for (int b = 1; b <= 6; b++) begin
      if (b >= 2 && b <= 5) set_cpu(1, 0, 32'h10, 32'h0);
      else set_cpu(0, 0, 32'h0, 32'h0);
      settle();
      chk_eq("t4_gnt", ext_if.ext_gnt, (b <= 4 || b == 6));
      chk_eq("t4_stall", StallM, (b >= 2 && b <= 4));
      advance();
      if (last_win) begin
        k++;
        set_ext(1, 1, 1, 32'h40 + 32'(4 * k), $urandom);
      end
    end
    set_ext(0, 0, 0, 32'h0, 32'h0);
    set_cpu(0, 0, 32'h0, 32'h0);
    settle(); chk_eq("t4_stall_count", stall_count, 32'd4); advance();

    // Reset in the middle of a locked read burst
    set_ext(1, 0, 1, 32'h20, 32'h0);
    settle(); chk_eq("t5_first_gnt", ext_if.ext_gnt, 1'b1); advance();
    rst = 1'b1;
    set_cpu(1, 0, 32'h10, 32'h0);
    settle(); chk_eq("t5_rst_cycle_gnt", ext_if.ext_gnt, 1'b0); advance();
    rst = 1'b0;
    settle();
    chk_eq("t5_gnt", ext_if.ext_gnt, 1'b0);
    chk_eq("t5_stall", StallM, 1'b0);
    chk_eq("t5_rvalid", ext_if.ext_rvalid, 1'b0);
    chk_eq("t5_rdata", ext_if.ext_rdata, 32'h0);
    chk_eq("t5_stall_count", stall_count, 32'd0);
    advance();

    // Narrow stall counter saturates
    set_ext(1, 0, 0, 32'h20, 32'h0);
    for (int c = 0; c < 30; c++) begin
      settle(); advance();
    end
    set_ext(0, 0, 0, 32'h0, 32'h0);
    set_cpu(0, 0, 32'h0, 32'h0);
    settle();
    chk_eq("t6_sat", {30'b0, stall_count2}, 32'd3);
    chk_eq("t6_wide_ge5", (stall_count >= 32'd5), 1'b1);
    advance();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
